// File: rtl/usb_pkg.sv
// Shared USB definitions: PID codes and the control-IN endpoint state encoding.
package usb_pkg;

  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [1:0] {
    EP_FILL     = 2'd0,
    EP_READY    = 2'd1,
    EP_XMIT     = 2'd2,
    EP_WAIT_ACK = 2'd3
  } ep_state_e;

  function automatic logic [3:0] data_pid(input logic toggle);
    return toggle ? PID_DATA1 : PID_DATA0;
  endfunction

endpackage

// File: rtl/usb_ep_pkt_buf.sv
// Endpoint packet RAM: one synchronous write port, one asynchronous read port.
module usb_ep_pkt_buf #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/usb_serial_in_ep.sv
// Control-IN endpoint: buffers upstream bytes into packets and answers IN tokens.
// Optional build macro USB_IN_EP_ACK_TIMEOUT_EN returns an unacknowledged packet to READY.
import usb_pkg::*;

module usb_serial_in_ep #(
  parameter int MAX_PKT_SIZE = 32,
  parameter int PTR_W        = $clog2(MAX_PKT_SIZE) + 1
`ifdef USB_IN_EP_ACK_TIMEOUT_EN
  , parameter int ACK_TIMEOUT = 18
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_ep_req,
  output logic       in_ep_grant,
  output logic       in_ep_data_free,
  input  logic       in_ep_data_put,
  input  logic [7:0] in_ep_data,
  input  logic       in_ep_data_done,
  input  logic       in_ep_stall,
  output logic       in_ep_acked,
  input  logic       setup_token,
  input  logic       token_in,
  input  logic       rx_ack,
  output logic       tx_pkt_start,
  output logic [3:0] tx_pid,
  output logic       tx_data_avail,
  input  logic       tx_data_get,
  output logic [7:0] tx_data,
  output logic [1:0] dbg_state
);

  // Handshakes: a byte moves upstream->buffer on a cycle where put, grant and
  // free are all high; buffer->engine on a cycle where tx_data_avail and
  // tx_data_get are both high. Neither side may assume a transfer otherwise.

  ep_state_e        state, state_next;
  logic [PTR_W-1:0] wr_ptr, rd_ptr, pkt_len, wr_next;
  logic             toggle, pending_done, pending_eff;
  logic             put_ok, fill_done, ack_ok, tok_valid;
  logic             tok_stall, tok_nak, tok_data, timeout_hit;

  assign dbg_state = state;

  usb_ep_pkt_buf #(
    .DEPTH (MAX_PKT_SIZE),
    .AW    (PTR_W - 1)
  ) u_buf (
    .clk   (clk),
    .we    (put_ok),
    .waddr (wr_ptr[PTR_W-2:0]),
    .wdata (in_ep_data),
    .raddr (rd_ptr[PTR_W-2:0]),
    .rdata (tx_data)
  );

  // Output / decode process
  always_comb begin
    in_ep_grant     = in_ep_req && (state == EP_FILL);
    in_ep_data_free = (state == EP_FILL) && (wr_ptr < PTR_W'(MAX_PKT_SIZE));
    tx_data_avail   = (state == EP_XMIT) && (rd_ptr < pkt_len);
    put_ok          = in_ep_data_put && in_ep_grant && in_ep_data_free;
    wr_next         = wr_ptr + PTR_W'(put_ok);
    fill_done       = (state == EP_FILL) &&
                      (in_ep_data_done || (wr_next == PTR_W'(MAX_PKT_SIZE)));
    ack_ok          = (state == EP_WAIT_ACK) && rx_ack && !setup_token;
    pending_eff     = pending_done || in_ep_data_done;
    // Tokens are not answered mid-packet, nor when a same-cycle ACK wins.
    tok_valid       = token_in && !setup_token && (state != EP_XMIT) && !ack_ok;
    tok_stall       = tok_valid && in_ep_stall;
    tok_nak         = tok_valid && !in_ep_stall && (state == EP_FILL);
    tok_data        = tok_valid && !in_ep_stall &&
                      ((state == EP_READY) || (state == EP_WAIT_ACK));
  end

  // Next-state process
  always_comb begin
    state_next = state;
    if (setup_token) begin
      state_next = EP_FILL;
    end else begin
      case (state)
        EP_FILL:     if (fill_done) state_next = EP_READY;
        EP_READY:    if (tok_data) state_next = EP_XMIT;
        EP_XMIT:     if (rd_ptr == pkt_len) state_next = EP_WAIT_ACK;
        EP_WAIT_ACK: begin
          if (ack_ok)           state_next = pending_eff ? EP_READY : EP_FILL;
          else if (tok_data)    state_next = EP_XMIT;
          else if (timeout_hit) state_next = EP_READY;
        end
        default:     state_next = EP_FILL;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= EP_FILL;
    else        state <= state_next;
  end

  // Pointer, length and toggle bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      pkt_len      <= '0;
      toggle       <= 1'b0;
      pending_done <= 1'b0;
    end else if (setup_token) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      pkt_len      <= '0;
      toggle       <= 1'b1;
      pending_done <= 1'b0;
    end else begin
      wr_ptr <= wr_next;
      if (fill_done) pkt_len <= wr_next;
      if (in_ep_data_done && (state != EP_FILL)) pending_done <= 1'b1;
      if (tok_data) rd_ptr <= '0;
      else if (tx_data_avail && tx_data_get) rd_ptr <= rd_ptr + 1'b1;
      if (ack_ok) begin
        toggle <= ~toggle;
        wr_ptr <= '0;
        rd_ptr <= '0;
        // A done that arrived while the buffer was busy becomes the terminating ZLP.
        if (pending_eff) begin
          pkt_len      <= '0;
          pending_done <= 1'b0;
        end
      end
    end
  end

  // Token response and upstream ACK notification, registered one cycle after the event
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_pkt_start <= 1'b0;
      tx_pid       <= 4'd0;
      in_ep_acked  <= 1'b0;
    end else begin
      tx_pkt_start <= tok_stall || tok_nak || tok_data;
      in_ep_acked  <= ack_ok;
      if (tok_stall)     tx_pid <= PID_STALL;
      else if (tok_nak)  tx_pid <= PID_NAK;
      else if (tok_data) tx_pid <= data_pid(toggle);
    end
  end

`ifdef USB_IN_EP_ACK_TIMEOUT_EN
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  logic [TO_W-1:0] ack_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     ack_cnt <= '0;
    else if (state != EP_WAIT_ACK)  ack_cnt <= '0;
    else if (!timeout_hit)          ack_cnt <= ack_cnt + 1'b1;
  end

  assign timeout_hit = (state == EP_WAIT_ACK) && (ack_cnt == TO_W'(ACK_TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: doc/usb_serial_in_ep.md
Name: usb_serial_in_ep

Overview:
- Control-IN endpoint packet buffer, directly downstream of the control endpoint.
- Accepts descriptor/status bytes over the in_ep req/grant/put/done handshake and segments them into packets of at most MAX_PKT_SIZE bytes.
- Answers IN tokens from the USB protocol engine with DATA0/DATA1, NAK or STALL, and reports host ACKs back upstream.

Parameters:
- MAX_PKT_SIZE, 32, packet buffer depth in bytes; must equal bMaxPacketSize0; power of two, 8..64.
- PTR_W, $clog2(MAX_PKT_SIZE)+1, pointer width; one extra bit so a full buffer is representable.

Ports:
- clk  in  1  system clock, 48 MHz domain.
- reset  in  1  asynchronous, active-low reset; all state clears while low.
- in_ep_req  in  1  upstream requests the buffer.
- in_ep_grant  out  1  buffer granted to upstream.
- in_ep_data_free  out  1  buffer can accept a byte this cycle.
- in_ep_data_put  in  1  byte write strobe.
- in_ep_data  in  8  byte to write.
- in_ep_data_done  in  1  pulse: transfer/packet complete; may be zero-length.
- in_ep_stall  in  1  level: answer every IN token with STALL.
- in_ep_acked  out  1  pulse: host ACKed a DATA packet.
- setup_token  in  1  pulse: SETUP token for this endpoint.
- token_in  in  1  pulse: IN token for this endpoint.
- rx_ack  in  1  pulse: ACK handshake received after our DATA packet.
- tx_pkt_start  out  1  pulse: begin response; tx_pid is valid.
- tx_pid  out  4  PID of the response.
- tx_data_avail  out  1  payload byte available.
- tx_data_get  in  1  engine consumes tx_data.
- tx_data  out  8  current payload byte, mem[rd_ptr].

Behaviour:
- States: FILL, READY, XMIT, WAIT_ACK.
- Reset values: state=FILL; wr_ptr, rd_ptr, pkt_len, toggle, pending_done all 0; tx_pid=0; tx_pkt_start, in_ep_acked, tx_data_avail, in_ep_grant all 0; in_ep_data_free=1.
- in_ep_grant = in_ep_req && state==FILL (combinational).
- in_ep_data_free = state==FILL && wr_ptr<MAX_PKT_SIZE.
- Write: when put && grant && free, mem[wr_ptr]<=in_ep_data and wr_ptr++.
- FILL -> READY in either case:
  - in_ep_data_done: pkt_len<=wr_ptr, counting a put in the same cycle.
  - wr_ptr reaches MAX_PKT_SIZE: pkt_len<=MAX_PKT_SIZE.
- in_ep_data_done outside FILL sets pending_done. On the next entry to FILL with pending_done set, go straight to READY with pkt_len=0 and clear pending_done. This produces the terminating ZLP when the transfer length is an exact multiple of MAX_PKT_SIZE.
- token_in response, one cycle later:
  - tx_pkt_start=1 with tx_pid chosen by priority: STALL if in_ep_stall; else NAK in FILL; else DATA0/DATA1 per toggle.
  - A DATA response from READY enters XMIT with rd_ptr=0.
  - Handshake responses (STALL, NAK) do not change state.
- XMIT:
  - tx_data_avail = rd_ptr<pkt_len; each tx_data_get increments rd_ptr.
  - When rd_ptr==pkt_len, go to WAIT_ACK. For pkt_len=0 this happens in the cycle after tx_pkt_start.
- WAIT_ACK:
  - rx_ack: toggle^=1; in_ep_acked pulses 1 cycle; wr_ptr, rd_ptr <= 0; state=FILL.
  - token_in (ACK was lost): retransmit with the same PID and buffer; rd_ptr=0; state=XMIT.
  - rx_ack and token_in in the same cycle: rx_ack wins, token ignored.
- setup_token has the highest priority below reset, in any state:
  - state=FILL; pointers, pkt_len and pending_done cleared; toggle=1, so the first data-stage packet is DATA1.
  - No in_ep_acked is generated.
- in_ep_stall asserted mid-XMIT does not abort the current packet. It applies from the next token onward.

Optional Feature:
- USB_IN_EP_ACK_TIMEOUT_EN, with parameter ACK_TIMEOUT (default 18 cycles).
- Defined: a counter starts on entry to WAIT_ACK. If no rx_ack arrives within ACK_TIMEOUT cycles, state returns to READY with the same toggle and buffer; the next token_in resends it.
- Undefined: no counter; WAIT_ACK is left only by rx_ack, token_in or setup_token.

Decomposition:
- Shared package usb_pkg holds:
  - PID constants: DATA0=4'b0011, DATA1=4'b1011, ACK=4'b0010, NAK=4'b1010, STALL=4'b1110.
  - The endpoint state enum.
- Natural sub-module usb_ep_pkt_buf: MAX_PKT_SIZE x 8 RAM with one synchronous write port and one asynchronous read port.

Test Plan:
- 18-byte device descriptor, MAX_PKT_SIZE=32, then token_in -> DATA1 (after setup_token), 18 bytes 0x12,0x01,0x00,0x02..., rx_ack -> in_ep_acked pulse, toggle=0.
- 67-byte config descriptor -> packets of 32 (DATA1), 32 (DATA0), 3 (DATA1); data_free low while each packet is READY or in transit.
- 64-byte transfer -> 32 (DATA1), 32 (DATA0), then ZLP DATA1 from pending_done.
- token_in while in FILL -> NAK. in_ep_stall=1 then token_in -> STALL with buffer contents unchanged.
- No rx_ack, second token_in -> identical packet with identical PID. setup_token mid-XMIT -> FILL, next response NAK, toggle=1.
- Reset asserted mid-XMIT -> all outputs at reset values immediately. With the macro defined, no ACK for 18 cycles -> READY, then resend.
